// File: rtl/inert_intf_ctrl.sv
// -----------------------------------------------------------------------------
// inert_intf_ctrl
// Sequencer between a 16-bit-transaction SPI master and the inertial sensor.
// After reset it waits for sensor power-up, writes four configuration
// registers, then on every data-ready interrupt reads pitch-rate L/H and
// AZ L/H, and publishes the assembled words with a one-cycle vld.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   INT      in   sensor data-ready interrupt (asynchronous to clk)
//   done     in   SPI transaction-complete pulse
//   rd_data  in   SPI read data, byte of interest in [7:0]
//   wrt      out  one-cycle pulse starting an SPI transaction
//   cmd      out  SPI command word, held from wrt until done
//   ptch_rt  out  assembled raw pitch rate {H,L}
//   AZ       out  assembled raw Z acceleration {H,L}
//   vld      out  one-cycle pulse, ptch_rt/AZ just updated
//   err      out  sticky transaction-timeout flag
//
// Build option: define INERT_TIMEOUT_EN to enable the per-transaction
// timeout (TIMEOUT_CYC cycles). Without it err is tied low and every
// transaction waits for done indefinitely.
// -----------------------------------------------------------------------------
module inert_intf_ctrl #(
  parameter int INIT_WAIT_BITS = 16,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        err
);

  typedef enum logic [3:0] {
    ST_PWRUP = 4'd0,
    ST_CFG0  = 4'd1,
    ST_CFG1  = 4'd2,
    ST_CFG2  = 4'd3,
    ST_CFG3  = 4'd4,
    ST_IDLE  = 4'd5,
    ST_RD_PL = 4'd6,
    ST_RD_PH = 4'd7,
    ST_RD_AL = 4'd8,
    ST_RD_AH = 4'd9,
    ST_PUB   = 4'd10
  } state_t;

  // Command word issued when a transaction state is entered.
  function automatic logic [15:0] f_cmd(input state_t s);
    logic [15:0] c;
    case (s)
      ST_CFG0:  c = 16'h0D02;
      ST_CFG1:  c = 16'h1053;
      ST_CFG2:  c = 16'h1150;
      ST_CFG3:  c = 16'h1460;
      ST_RD_PL: c = 16'hA400;
      ST_RD_PH: c = 16'hA500;
      ST_RD_AL: c = 16'hAC00;
      ST_RD_AH: c = 16'hAD00;
      default:  c = 16'h0000;
    endcase
    return c;
  endfunction

  // Successor of a transaction state once its done arrives.
  function automatic state_t f_next_xfer(input state_t s);
    state_t n;
    case (s)
      ST_CFG0:  n = ST_CFG1;
      ST_CFG1:  n = ST_CFG2;
      ST_CFG2:  n = ST_CFG3;
      ST_CFG3:  n = ST_IDLE;
      ST_RD_PL: n = ST_RD_PH;
      ST_RD_PH: n = ST_RD_AL;
      ST_RD_AL: n = ST_RD_AH;
      ST_RD_AH: n = ST_PUB;
      default:  n = ST_PWRUP;
    endcase
    return n;
  endfunction

  // True for states that own an SPI transaction and wait for done.
  function automatic logic f_is_xfer(input state_t s);
    logic x;
    case (s)
      ST_CFG0, ST_CFG1, ST_CFG2, ST_CFG3,
      ST_RD_PL, ST_RD_PH, ST_RD_AL, ST_RD_AH: x = 1'b1;
      default:                               x = 1'b0;
    endcase
    return x;
  endfunction

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [INIT_WAIT_BITS-1:0] r_wait_cnt;
  logic                      r_int_ff1;
  logic                      r_int_ff2;
  logic                      r_int_prev;
  logic                      r_pending;
  logic                      r_wrt;
  logic [15:0]               r_cmd;
  logic [7:0]                r_pl;
  logic [7:0]                r_ph;
  logic [7:0]                r_al;
  logic [15:0]               r_ptch_rt;
  logic [15:0]               r_az;
  logic                      r_vld;
  logic                      w_int_rise;
  logic                      w_xfer;
  logic                      w_start;
  logic                      w_clr_pend;
  logic                      w_timeout;
  logic                      w_unused;

  assign w_int_rise = r_int_ff2 & ~r_int_prev;
  assign w_xfer     = f_is_xfer(r_state);

  // Upper read byte is don't-care; TIMEOUT_CYC only matters with the timeout built in.
  assign w_unused = &{1'b0, rd_data[15:8], (TIMEOUT_CYC > 0)};

  // INT synchronizer plus edge-detect flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_int_ff1  <= 1'b0;
      r_int_ff2  <= 1'b0;
      r_int_prev <= 1'b0;
    end else begin
      r_int_ff1  <= INT;
      r_int_ff2  <= r_int_ff1;
      r_int_prev <= r_int_ff2;
    end
  end

  // Pending read request; a rise coinciding with a sequence start wins so
  // that the newer sample is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (w_int_rise) begin
      r_pending <= 1'b1;
    end else if (w_clr_pend) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Power-up wait counter, running only while in PWRUP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= {INIT_WAIT_BITS{1'b0}};
    end else if (r_state == ST_PWRUP) begin
      r_wait_cnt <= r_wait_cnt + INIT_WAIT_BITS'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_PWRUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; w_start marks the cycle before a transaction's wrt.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_clr_pend  = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (&r_wait_cnt) begin
          w_state_nxt = ST_CFG0;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_PWRUP;
        end
      end
      ST_CFG0, ST_CFG1, ST_CFG2, ST_CFG3: begin
        if (done) begin
          w_state_nxt = f_next_xfer(r_state);
          w_start     = (r_state != ST_CFG3);
        end else if (w_timeout) begin
          // Retry the same configuration write.
          w_state_nxt = r_state;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_IDLE: begin
        if (r_pending) begin
          w_state_nxt = ST_RD_PL;
          w_start     = 1'b1;
          w_clr_pend  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_PL, ST_RD_PH, ST_RD_AL, ST_RD_AH: begin
        if (done) begin
          w_state_nxt = f_next_xfer(r_state);
          w_start     = (r_state != ST_RD_AH);
        end else if (w_timeout) begin
          // Abandon the sequence; shadows never reach the outputs.
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_PUB: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_PWRUP;
      end
    endcase
  end

  // SPI request: wrt lines up with the first cycle of the new state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrt <= 1'b0;
      r_cmd <= 16'h0000;
    end else if (w_start) begin
      r_wrt <= 1'b1;
      r_cmd <= f_cmd(w_state_nxt);
    end else begin
      r_wrt <= 1'b0;
      r_cmd <= r_cmd;
    end
  end

  // Byte shadows captured on done; AH goes straight to the output word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pl <= 8'h00;
      r_ph <= 8'h00;
      r_al <= 8'h00;
    end else if (done && (r_state == ST_RD_PL)) begin
      r_pl <= rd_data[7:0];
    end else if (done && (r_state == ST_RD_PH)) begin
      r_ph <= rd_data[7:0];
    end else if (done && (r_state == ST_RD_AL)) begin
      r_al <= rd_data[7:0];
    end else begin
      r_pl <= r_pl;
      r_ph <= r_ph;
      r_al <= r_al;
    end
  end

  // Publish: outputs load on entry to PUB so vld coincides with new values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptch_rt <= 16'h0000;
      r_az      <= 16'h0000;
      r_vld     <= 1'b0;
    end else if (done && (r_state == ST_RD_AH)) begin
      r_ptch_rt <= {r_ph, r_pl};
      r_az      <= {rd_data[7:0], r_al};
      r_vld     <= 1'b1;
    end else begin
      r_ptch_rt <= r_ptch_rt;
      r_az      <= r_az;
      r_vld     <= 1'b0;
    end
  end

`ifdef INERT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  // Cycles spent waiting in the current transaction; cleared with wrt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (w_start) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (w_xfer) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  assign w_timeout = w_xfer & ~done & (r_to_cnt == TO_LAST);

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_timeout;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign wrt     = r_wrt;
  assign cmd     = r_cmd;
  assign ptch_rt = r_ptch_rt;
  assign AZ      = r_az;
  assign vld     = r_vld;

endmodule
